// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (imem) and data (dmem) requesters.
// Fixed dmem priority by default; define MEM_ARB_RR_EN for round-robin tie-break on collisions.
module mem_port_arbiter #(
  parameter int XLEN   = 32,
  parameter int MASK_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   imem_addr,
  input  logic [MASK_W-1:0] imem_rmask,
  output logic [XLEN-1:0]   imem_rdata,
  output logic              imem_resp,
  input  logic [XLEN-1:0]   dmem_addr,
  input  logic [MASK_W-1:0] dmem_rmask,
  input  logic [MASK_W-1:0] dmem_wmask,
  input  logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN-1:0]   dmem_rdata,
  output logic              dmem_resp,
  output logic [XLEN-1:0]   mem_addr,
  output logic [MASK_W-1:0] mem_rmask,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;
  state_t              state_q, state_d;
  logic                i_pend_q, i_pend_d, d_pend_q, d_pend_d;
  logic [XLEN-1:0]     i_addr_q, i_addr_d, d_addr_q, d_addr_d, d_wdata_q, d_wdata_d;
  logic [MASK_W-1:0]   i_rmask_q, i_rmask_d, d_rmask_q, d_rmask_d, d_wmask_q, d_wmask_d;
  logic                i_req, d_req, idle, gnt_i, gnt_d;
  assign i_req = |imem_rmask;
  assign d_req = |(dmem_rmask | dmem_wmask);
  assign idle  = (state_q == IDLE);
`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  // last_q: 0 = imem granted last, 1 = dmem granted last
  assign gnt_d = idle && d_pend_q && (!i_pend_q || !last_q);
  assign gnt_i = idle && i_pend_q && !gnt_d;
  assign last_d = gnt_d ? 1'b1 : gnt_i ? 1'b0 : last_q;
`else
  assign gnt_d = idle && d_pend_q;
  assign gnt_i = idle && i_pend_q && !d_pend_q;
`endif
  always_comb begin
    i_pend_d  = i_pend_q & ~gnt_i;
    i_addr_d  = i_addr_q;
    i_rmask_d = i_rmask_q;
    d_pend_d  = d_pend_q & ~gnt_d;
    d_addr_d  = d_addr_q;
    d_rmask_d = d_rmask_q;
    d_wmask_d = d_wmask_q;
    d_wdata_d = d_wdata_q;
    if (i_req && !i_pend_q) begin
      i_pend_d  = 1'b1;
      i_addr_d  = imem_addr;
      i_rmask_d = imem_rmask;
    end
    if (d_req && !d_pend_q) begin
      d_pend_d  = 1'b1;
      d_addr_d  = dmem_addr;
      d_rmask_d = dmem_rmask;
      d_wmask_d = dmem_wmask;
      d_wdata_d = dmem_wdata;
    end
    state_d = idle ? (gnt_d ? D_WAIT : gnt_i ? I_WAIT : IDLE)
                   : (mem_resp ? IDLE : state_q);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      i_pend_q  <= 1'b0;
      i_addr_q  <= '0;
      i_rmask_q <= '0;
      d_pend_q  <= 1'b0;
      d_addr_q  <= '0;
      d_rmask_q <= '0;
      d_wmask_q <= '0;
      d_wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      i_pend_q  <= i_pend_d;
      i_addr_q  <= i_addr_d;
      i_rmask_q <= i_rmask_d;
      d_pend_q  <= d_pend_d;
      d_addr_q  <= d_addr_d;
      d_rmask_q <= d_rmask_d;
      d_wmask_q <= d_wmask_d;
      d_wdata_q <= d_wdata_d;
`ifdef MEM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end
  assign mem_addr   = gnt_d ? d_addr_q : gnt_i ? i_addr_q : '0;
  assign mem_rmask  = gnt_d ? d_rmask_q : gnt_i ? i_rmask_q : '0;
  assign mem_wmask  = gnt_d ? d_wmask_q : '0;
  assign mem_wdata  = gnt_d ? d_wdata_q : '0;
  assign imem_resp  = (state_q == I_WAIT) && mem_resp;
  assign dmem_resp  = (state_q == D_WAIT) && mem_resp;
  assign imem_rdata = imem_resp ? mem_rdata : '0;
  assign dmem_rdata = dmem_resp ? mem_rdata : '0;
  assign busy       = !idle;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, reset corner sequences and a randomized run
// against a request-level reference model of the arbiter.
module tb_mem_port_arbiter;
  logic        clk = 0, rst = 0;
  logic [31:0] imem_addr = 0, imem_rdata, dmem_addr = 0, dmem_wdata = 0, dmem_rdata;
  logic [3:0]  imem_rmask = 0, dmem_rmask = 0, dmem_wmask = 0;
  logic        imem_resp, dmem_resp, mem_resp = 0, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_rmask, mem_wmask;
  int errs = 0, checks = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  irm;  logic [31:0] ia;
    logic [3:0]  drm;  logic [3:0]  dwm; logic [31:0] da; logic [31:0] dwd;
    logic        mr;   logic [31:0] mrd;
    logic [31:0] ema;  logic [3:0]  emrm; logic [3:0] emwm; logic [31:0] emwd;
    logic        eir;  logic [31:0] eird; logic edr; logic [31:0] edrd; logic eb;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] irm, input logic [31:0] ia,
      input logic [3:0] drm, input logic [3:0] dwm, input logic [31:0] da, input logic [31:0] dwd,
      input logic mr, input logic [31:0] mrd,
      input logic [31:0] ema, input logic [3:0] emrm, input logic [3:0] emwm, input logic [31:0] emwd,
      input logic eir, input logic [31:0] eird, input logic edr, input logic [31:0] edrd, input logic eb);
    vec_t v;
    v.irm = irm; v.ia = ia; v.drm = drm; v.dwm = dwm; v.da = da; v.dwd = dwd; v.mr = mr; v.mrd = mrd;
    v.ema = ema; v.emrm = emrm; v.emwm = emwm; v.emwd = emwd;
    v.eir = eir; v.eird = eird; v.edr = edr; v.edrd = edrd; v.eb = eb;
    return v;
  endfunction

  function automatic logic [138:0] outs();
    return {mem_addr, mem_rmask, mem_wmask, mem_wdata, imem_resp, imem_rdata, dmem_resp, dmem_rdata, busy};
  endfunction

  task automatic chk(input string name, input logic [138:0] act, input logic [138:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got {addr,rm,wm,wd,ir,ird,dr,drd,busy}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] irm, input logic [31:0] ia, input logic [3:0] drm,
      input logic [3:0] dwm, input logic [31:0] da, input logic [31:0] dwd, input logic mr, input logic [31:0] mrd);
    imem_rmask = irm; imem_addr = ia; dmem_rmask = drm; dmem_wmask = dwm;
    dmem_addr = da; dmem_wdata = dwd; mem_resp = mr; mem_rdata = mrd;
  endtask

  // reference model: outstanding owner (0 none, 1 imem, 2 dmem) and at most one held request per side
  int          owner = 0, pick;
  bit          ip = 0, dp = 0;
  logic [31:0] m_ia, m_da, m_dwd;
  logic [3:0]  m_irm, m_drm, m_dwm;

  vec_t tv[27];
  logic [138:0] z = '0;

  initial begin
    tv[0]  = mk(4'hF,32'h6000_0000,0,0,0,0,0,0,                0,0,0,0,0,0,0,0,0);
    tv[1]  = mk(0,0,0,0,0,0,0,0,                                32'h6000_0000,4'hF,0,0,0,0,0,0,0);
    tv[2]  = mk(0,0,0,0,0,0,0,0,                                0,0,0,0,0,0,0,0,1);
    tv[3]  = mk(0,0,0,0,0,0,1,32'h13,                           0,0,0,0,1,32'h13,0,0,1);
    tv[4]  = mk(0,0,0,0,0,0,0,0,                                0,0,0,0,0,0,0,0,0);
    tv[5]  = mk(0,0,0,4'h3,32'h100,32'hDEAD_BEEF,0,0,           0,0,0,0,0,0,0,0,0);
    tv[6]  = mk(0,0,0,0,0,0,0,0,                                32'h100,0,4'h3,32'hDEAD_BEEF,0,0,0,0,0);
    tv[7]  = mk(0,0,0,0,0,0,1,32'h5555,                         0,0,0,0,0,0,1,32'h5555,1);
    tv[8]  = mk(0,0,0,0,0,0,0,0,                                0,0,0,0,0,0,0,0,0);
    tv[9]  = mk(4'hF,32'h40,4'hF,0,32'h200,0,0,0,               0,0,0,0,0,0,0,0,0);
    tv[10] = mk(0,0,0,0,0,0,0,0,                                32'h200,4'hF,0,0,0,0,0,0,0);
    tv[11] = mk(0,0,0,0,0,0,0,0,                                0,0,0,0,0,0,0,0,1);
    tv[12] = mk(0,0,0,0,0,0,1,32'hAAAA,                         0,0,0,0,0,0,1,32'hAAAA,1);
    tv[13] = mk(0,0,0,0,0,0,0,0,                                32'h40,4'hF,0,0,0,0,0,0,0);
    tv[14] = mk(0,0,0,0,0,0,0,0,                                0,0,0,0,0,0,0,0,1);
    tv[15] = mk(4'hF,32'h44,0,0,0,0,1,32'hBBBB,                 0,0,0,0,1,32'hBBBB,0,0,1);
    tv[16] = mk(0,0,0,0,0,0,0,0,                                32'h44,4'hF,0,0,0,0,0,0,0);
    tv[17] = mk(0,0,0,0,0,0,1,32'hCC,                           0,0,0,0,1,32'hCC,0,0,1);
    tv[18] = mk(0,0,0,0,0,0,1,32'h77,                           0,0,0,0,0,0,0,0,0);
    tv[19] = mk(0,0,4'h1,0,32'h300,0,0,0,                       0,0,0,0,0,0,0,0,0);
    tv[20] = mk(4'hF,32'h4,0,0,0,0,0,0,                         32'h300,4'h1,0,0,0,0,0,0,0);
    tv[21] = mk(4'hF,32'h8,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0,1);
    tv[22] = mk(0,0,0,0,0,0,1,32'h1,                            0,0,0,0,0,0,1,32'h1,1);
    tv[23] = mk(0,0,0,0,0,0,0,0,                                32'h4,4'hF,0,0,0,0,0,0,0);
    tv[24] = mk(0,0,0,0,0,0,1,32'h2,                            0,0,0,0,1,32'h2,0,0,1);
    tv[25] = mk(0,0,0,0,0,0,0,0,                                0,0,0,0,0,0,0,0,0);
    tv[26] = mk(0,0,0,0,0,0,0,0,                                0,0,0,0,0,0,0,0,0);

    repeat (2) @(posedge clk);
    #2 chk("reset_outputs", outs(), z);
    rst = 1;

    for (int i = 0; i < 27; i++) begin
      @(posedge clk); #2;
      drive(tv[i].irm, tv[i].ia, tv[i].drm, tv[i].dwm, tv[i].da, tv[i].dwd, tv[i].mr, tv[i].mrd);
      #2 chk($sformatf("vec%0d", i), outs(),
             {tv[i].ema, tv[i].emrm, tv[i].emwm, tv[i].emwd, tv[i].eir, tv[i].eird, tv[i].edr, tv[i].edrd, tv[i].eb});
    end

    for (int c = 0; c < 2000; c++) begin
      logic        ireq, dreq, mr;
      logic [3:0]  irm, drm, dwm;
      logic [31:0] ia, da, dwd, mrd, ema, emwd, eird, edrd;
      logic [3:0]  emrm, emwm;
      logic        eir, edr;
      ireq = ($urandom_range(0, 2) == 0);
      dreq = ($urandom_range(0, 2) == 0);
      irm  = ireq ? 4'($urandom_range(1, 15)) : 4'h0;
      drm  = dreq ? 4'($urandom_range(0, 15)) : 4'h0;
      dwm  = !dreq ? 4'h0 : (drm == 0) ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
      ia = $urandom; da = $urandom; dwd = $urandom; mrd = $urandom;
      mr = ($urandom_range(0, 2) == 0);
      @(posedge clk); #2;
      drive(irm, ia, drm, dwm, da, dwd, mr, mrd);
      ema = 0; emrm = 0; emwm = 0; emwd = 0; eir = 0; eird = 0; edr = 0; edrd = 0;
      pick = 0;
      if (owner == 0) begin
        pick = dp ? 2 : ip ? 1 : 0;
        if (pick == 2) begin ema = m_da; emrm = m_drm; emwm = m_dwm; emwd = m_dwd; end
        if (pick == 1) begin ema = m_ia; emrm = m_irm; end
      end else if (mr) begin
        if (owner == 1) begin eir = 1; eird = mrd; end
        else begin edr = 1; edrd = mrd; end
      end
      #2 chk($sformatf("rand%0d", c), outs(),
             {ema, emrm, emwm, emwd, eir, eird, edr, edrd, owner != 0});
      if (owner != 0 && mr) owner = 0;
      else if (pick != 0) owner = pick;
      if (ireq && !ip) begin m_ia = ia; m_irm = irm; end
      if (dreq && !dp) begin m_da = da; m_drm = drm; m_dwm = dwm; m_dwd = dwd; end
      ip = (ip && pick != 1) || (ireq && !ip);
      dp = (dp && pick != 2) || (dreq && !dp);
    end

    // drain the random run before the reset corner
    @(posedge clk); #2 drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2 drive(0, 0, 4'hF, 4'hF, 32'h500, 32'h1234, 0, 0);
    @(posedge clk); #2 drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2 chk("pre_reset_busy", {138'b0, busy}, {138'b0, 1'b1});
    #1 rst = 0;
    #1 chk("reset_mid_txn", outs(), z);
    @(posedge clk); #2 rst = 1;
    #1 drive(0, 0, 0, 0, 0, 0, 1, 32'hFFFF);
    #1 chk("late_resp_ignored", outs(), z);
    @(posedge clk); #2 drive(0, 0, 4'hF, 0, 32'h600, 0, 0, 0);
    #2 chk("post_reset_idle", outs(), z);
    @(posedge clk); #2 drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("post_reset_grant", outs(), {32'h600, 4'hF, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0});
    @(posedge clk); #2 drive(0, 0, 0, 0, 0, 0, 1, 32'h99);
    #2 chk("post_reset_resp", outs(), {32'h0, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h99, 1'b1});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
